// File: rtl/pool_arbiter.sv
// ============================================================================
// pool_arbiter : round-robin sequencer sharing one pooling engine among NREQ
//                requesters; results are returned tagged with requester id.
// Revision 1.0
// ============================================================================
`default_nettype none

module pool_arbiter #(
    parameter int IL   = 8,
    parameter int FL   = 12,
    parameter int SIZE = 4,
    parameter int NREQ = 4,
    parameter int REQW = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*SIZE*(IL+FL)-1:0] req_im,
    input  logic [2*NREQ-1:0]          req_mode,
    output logic [NREQ-1:0]            gnt,
    output logic [SIZE*(IL+FL)-1:0]    pool_im,
    output logic [1:0]                 pool_mode,
    output logic                       pool_input_ready,
    output logic                       pool_output_taken,
    input  logic [IL+FL-1:0]           pool_om,
    input  logic [1:0]                 pool_state,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [REQW-1:0]            rsp_id,
    output logic [IL+FL-1:0]           rsp_om,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int W   = IL + FL;
    localparam int WIN = SIZE * W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    localparam logic [1:0] ENG_IDLE = 2'b00;
    localparam logic [1:0] ENG_DONE = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [REQW-1:0] last_q, id_q;
    logic [NREQ-1:0] gnt_q;
    logic [WIN-1:0]  pool_im_q;
    logic [1:0]      pool_mode_q;
    logic            rsp_valid_q, rsp_err_q;
    logic [REQW-1:0] rsp_id_q;
    logic [W-1:0]    rsp_om_q;

    logic            w_found;
    logic [REQW-1:0] w_sel, w_idx;
    logic [WIN-1:0]  w_win;
    logic [1:0]      w_mode;
    logic            w_take;

    // Scan starts just past the last served requester, so it has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = REQW'((int'(last_q) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_win  = '0;
        w_mode = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (w_sel == REQW'(r)) begin
                w_win  = req_im[r*WIN +: WIN];
                w_mode = req_mode[2*r +: 2];
            end
        end
    end

    assign w_take = (state_q == S_IDLE) && w_found && (pool_state == ENG_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (w_take) state_d = (w_mode == MODE_BAD) ? S_DELIVER : S_LAUNCH;
            S_LAUNCH:  state_d = S_WAIT;
            S_WAIT:    if (pool_state == ENG_DONE) state_d = S_DELIVER;
            S_DELIVER: if (rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= REQW'(NREQ - 1);
            id_q        <= '0;
            gnt_q       <= '0;
            pool_im_q   <= '0;
            pool_mode_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_om_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= '0;
            if (w_take) begin
                pool_im_q   <= w_win;
                pool_mode_q <= w_mode;
                id_q        <= w_sel;
                gnt_q       <= NREQ'(1) << w_sel;
                // An invalid mode never reaches the engine; answer immediately.
                if (w_mode == MODE_BAD) begin
                    rsp_om_q    <= '0;
                    rsp_err_q   <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= w_sel;
                end
            end
            if (state_q == S_WAIT && pool_state == ENG_DONE) begin
                rsp_om_q    <= pool_om;
                rsp_err_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
            end
            if (state_q == S_DELIVER && rsp_ready) begin
                rsp_valid_q <= 1'b0;
                last_q      <= id_q;
            end
        end
    end

    assign gnt               = gnt_q;
    assign pool_im           = pool_im_q;
    assign pool_mode         = pool_mode_q;
    assign pool_input_ready  = (state_q == S_LAUNCH);
    assign pool_output_taken = (state_q == S_WAIT) && (pool_state == ENG_DONE);
    assign rsp_valid         = rsp_valid_q;
    assign rsp_id            = rsp_id_q;
    assign rsp_om            = rsp_om_q;
    assign rsp_err           = rsp_err_q;
    assign busy              = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pool_arbiter.sv
// ============================================================================
// tb_pool_arbiter : directed scoreboard bench for pool_arbiter with a simple
//                   behavioural pooling engine. Revision 1.0
// ============================================================================
`default_nettype none

module tb_pool_arbiter;

    localparam int IL = 8, FL = 12, W = 20, SIZE = 4, NREQ = 4, REQW = 2;
    localparam int WIN = SIZE * W;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIN-1:0]   req_im;
    logic [2*NREQ-1:0]     req_mode;
    logic [NREQ-1:0]       gnt;
    logic [WIN-1:0]        pool_im;
    logic [1:0]            pool_mode;
    logic                  pool_input_ready, pool_output_taken;
    logic [W-1:0]          pool_om;
    logic [1:0]            pool_state;
    logic                  rsp_valid, rsp_ready;
    logic [REQW-1:0]       rsp_id;
    logic [W-1:0]          rsp_om;
    logic                  rsp_err, busy;

    pool_arbiter #(.IL(IL), .FL(FL), .SIZE(SIZE), .NREQ(NREQ), .REQW(REQW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_im(req_im), .req_mode(req_mode),
        .gnt(gnt), .pool_im(pool_im), .pool_mode(pool_mode),
        .pool_input_ready(pool_input_ready), .pool_output_taken(pool_output_taken),
        .pool_om(pool_om), .pool_state(pool_state),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_om(rsp_om), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pool_ref(input logic [WIN-1:0] win, input logic [1:0] mode);
        logic signed [W-1:0] v, mx, mn;
        logic signed [W+1:0] sum;
        mx = $signed(win[W-1:0]);
        mn = mx;
        sum = '0;
        for (int k = 0; k < SIZE; k++) begin
            v = $signed(win[k*W +: W]);
            if (v > mx) mx = v;
            if (v < mn) mn = v;
            sum = sum + (W+2)'(v);
        end
        case (mode)
            2'b00:   return mx;
            2'b01:   return W'(sum >>> 2);
            2'b10:   return mn;
            default: return '0;
        endcase
    endfunction

    // Behavioural engine: idle -> busy (3 cycles) -> done until output_taken.
    logic [1:0] eng_state;
    logic [W-1:0] eng_om;
    int eng_cnt;
    always @(posedge clk) begin
        if (reset) begin
            eng_state <= 2'b00;
            eng_om    <= '0;
            eng_cnt   <= 0;
        end else begin
            case (eng_state)
                2'b00: if (pool_input_ready) begin
                    eng_state <= 2'b01;
                    eng_cnt   <= 3;
                    eng_om    <= pool_ref(pool_im, pool_mode);
                end
                2'b01: if (eng_cnt <= 1) eng_state <= 2'b10; else eng_cnt <= eng_cnt - 1;
                2'b10: if (pool_output_taken) eng_state <= 2'b00;
                default: eng_state <= 2'b00;
            endcase
        end
    end
    assign pool_state = eng_state;
    assign pool_om    = eng_om;

    typedef struct {
        logic [REQW-1:0] id;
        logic [W-1:0]    om;
        logic            err;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input int r, input logic [1:0] mode, input logic [WIN-1:0] win);
        req_im[r*WIN +: WIN] = win;
        req_mode[2*r +: 2]   = mode;
        req[r]               = 1'b1;
    endtask

    task automatic take_gnt(input int r, input logic [1:0] mode, input logic [WIN-1:0] win,
                            input logic [W-1:0] exp_om, input logic exp_err);
        exp_t e;
        logic [NREQ-1:0] one;
        one = '0;
        one[r] = 1'b1;
        for (int i = 0; i < 20 && gnt == '0; i++) tick();
        chk("gnt", gnt, one);
        chk("input_ready", pool_input_ready, (mode != 2'b11));
        chk("pool_mode", pool_mode, mode);
        chk("pool_im", pool_im, win);
        req[r] = 1'b0;
        e.id = REQW'(r);
        e.om = exp_om;
        e.err = exp_err;
        sb.push_back(e);
    endtask

    task automatic wait_rsp();
        exp_t e;
        for (int i = 0; i < 50 && !rsp_valid; i++) tick();
        chk("rsp_valid", rsp_valid, 1'b1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_om", rsp_om, e.om);
            chk("rsp_err", rsp_err, e.err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    logic [WIN-1:0] win_a, win_b, win_bad;
    logic [WIN-1:0] rr_win [NREQ];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Word 0 in the low bits: {1.0, -2.0, 3.5, 0.25}
        win_a   = {20'h00400, 20'h03800, 20'hFE000, 20'h01000};
        win_b   = {20'h00010, 20'hFFF00, 20'h00800, 20'h02000};
        win_bad = {20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF};
        reset = 1'b1; req = '0; req_im = '0; req_mode = '0; rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_pool_im", pool_im, 0);
        chk("rst_pool_mode", pool_mode, 0);
        chk("rst_input_ready", pool_input_ready, 0);
        chk("rst_output_taken", pool_output_taken, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Max, mean, min on requester 2
        raise(2, 2'b00, win_a); take_gnt(2, 2'b00, win_a, 20'h03800, 1'b0); wait_rsp();
        raise(2, 2'b01, win_a); take_gnt(2, 2'b01, win_a, 20'h00B00, 1'b0); wait_rsp();
        raise(2, 2'b10, win_a); take_gnt(2, 2'b10, win_a, 20'hFE000, 1'b0); wait_rsp();

        // Invalid mode on requester 1
        raise(1, 2'b11, win_a); take_gnt(1, 2'b11, win_a, 20'h00000, 1'b1); wait_rsp();

        // Back-pressure in DELIVER with another requester pending
        raise(0, 2'b00, win_b); take_gnt(0, 2'b00, win_b, 20'h02000, 1'b0);
        for (int i = 0; i < 50 && !rsp_valid; i++) tick();
        raise(3, 2'b00, win_a);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_om", rsp_om, 20'h02000);
            chk("stall_id", rsp_id, 2'd0);
            chk("stall_gnt", gnt, 0);
            chk("stall_input_ready", pool_input_ready, 0);
        end
        wait_rsp();
        take_gnt(3, 2'b00, win_a, 20'h03800, 1'b0); wait_rsp();

        // Window altered after the grant is ignored
        raise(1, 2'b10, win_a); take_gnt(1, 2'b10, win_a, 20'hFE000, 1'b0);
        req_im[1*WIN +: WIN] = win_bad;
        wait_rsp();

        // Reset while waiting on the engine
        raise(2, 2'b00, win_a); take_gnt(2, 2'b00, win_a, 20'h03800, 1'b0);
        tick();
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_pool_im", pool_im, 0);
        chk("mid_rst_pool_mode", pool_mode, 0);
        chk("mid_rst_input_ready", pool_input_ready, 0);
        chk("mid_rst_output_taken", pool_output_taken, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        chk("mid_rst_rsp_om", rsp_om, 0);
        chk("mid_rst_rsp_err", rsp_err, 0);
        chk("mid_rst_busy", busy, 0);
        raise(3, 2'b00, win_a); take_gnt(3, 2'b00, win_a, 20'h03800, 1'b0); wait_rsp();

        // All requesters continuously requesting: order 0,1,2,3,0,1
        for (int r = 0; r < NREQ; r++) begin
            for (int k = 0; k < SIZE; k++) rr_win[r][k*W +: W] = W'($urandom);
            raise(r, 2'b00, rr_win[r]);
        end
        for (int k = 0; k < 6; k++) begin
            take_gnt(k % NREQ, 2'b00, rr_win[k % NREQ], pool_ref(rr_win[k % NREQ], 2'b00), 1'b0);
            if (k == 5) req = '0;
            tick();
            if (k < 5) req[k % NREQ] = 1'b1;
            wait_rsp();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
